// File: rtl/mem_bus_responder.sv
// ============================================================================
// mem_bus_responder: CPU memory-bus slave with word RAM, wait states,
// pipelined read responses and an MMIO result window.
// Optional sticky protocol checking is enabled by defining MEM_RESP_ERRCHK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1,
  parameter int          RD_LATENCY  = 2,
  parameter logic [15:0] MMIO_BASE   = 16'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic        o_mem_wait,
  output logic [15:0] o_mem_rddata,
  output logic        o_mem_rddatavalid,
  output logic        o_int_valid,
  output logic [15:0] o_int_data,
  output logic        o_str_valid,
  output logic [15:0] o_str_addr,
  output logic        o_err
);

  localparam int WCNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_CYCLES);
  localparam int RAM_AW = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);

  logic        req;
  logic        wait_now;
  logic        accept;
  logic        rd_acc;
  logic        wr_acc;
  logic        mmio_hit;
  logic        ram_hit;
  logic [2:0]  mmio_off;
  logic [15:0] rd_word;

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       int_data_q, int_data_d;
  logic [15:0]       str_addr_q, str_addr_d;
  logic [15:0]       count_q, count_d;
  logic              int_valid_q, int_valid_d;
  logic              str_valid_q, str_valid_d;

  logic [RD_LATENCY-1:0] pvld_q, pvld_d;
  logic [15:0]           pdat_q [RD_LATENCY];
  logic [15:0]           pdat_d [RD_LATENCY];

  logic [15:0] mem [DEPTH_WORDS];

  always_comb begin
    req      = i_mem_rd | i_mem_wr;
    wait_now = req && (wcnt_q != WCNT_MAX);
    accept   = req && !wait_now;
    wr_acc   = accept && i_mem_wr;
    // A combined rd+wr is treated as a write only.
    rd_acc   = accept && i_mem_rd && !i_mem_wr;
    mmio_hit = (i_mem_addr[15:4] == MMIO_BASE[15:4]);
    ram_hit  = ({17'd0, i_mem_addr[15:1]} < $unsigned(DEPTH_WORDS));
    mmio_off = i_mem_addr[3:1];
  end

  always_comb begin
    rd_word = 16'h0000;
    if (mmio_hit) begin
      case (mmio_off)
        3'd0:    rd_word = int_data_q;
        3'd1:    rd_word = str_addr_q;
        3'd2:    rd_word = count_q;
        default: rd_word = 16'h0000;
      endcase
    end else if (ram_hit) begin
      rd_word = mem[i_mem_addr[RAM_AW:1]];
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (!req || accept) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_comb begin
    int_valid_d = 1'b0;
    str_valid_d = 1'b0;
    int_data_d  = int_data_q;
    str_addr_d  = str_addr_q;
    count_d     = count_q;
    if (wr_acc && mmio_hit) begin
      case (mmio_off)
        3'd0: begin
          int_data_d  = i_mem_wrdata;
          int_valid_d = 1'b1;
          count_d     = count_q + 16'd1;
        end
        3'd1: begin
          str_addr_d  = i_mem_wrdata;
          str_valid_d = 1'b1;
          count_d     = count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage 0 captures the word at the accept edge; the last stage drives the bus.
  always_comb begin
    pvld_d = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      pdat_d[i] = 16'h0000;
    end
    pvld_d[0] = rd_acc;
    pdat_d[0] = rd_acc ? rd_word : 16'h0000;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pdat_d[i] = pdat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt_q      <= '0;
      int_data_q  <= 16'h0000;
      str_addr_q  <= 16'h0000;
      count_q     <= 16'h0000;
      int_valid_q <= 1'b0;
      str_valid_q <= 1'b0;
      pvld_q      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pdat_q[i] <= 16'h0000;
      end
    end else begin
      wcnt_q      <= wcnt_d;
      int_data_q  <= int_data_d;
      str_addr_q  <= str_addr_d;
      count_q     <= count_d;
      int_valid_q <= int_valid_d;
      str_valid_q <= str_valid_d;
      pvld_q      <= pvld_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pdat_q[i] <= pdat_d[i];
      end
    end
  end

  // RAM contents survive reset; only writes are blocked while it is held.
  always_ff @(posedge clk) begin
    if (reset && wr_acc && !mmio_hit && ram_hit) begin
      mem[i_mem_addr[RAM_AW:1]] <= i_mem_wrdata;
    end
  end

`ifdef MEM_RESP_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (accept && ((i_mem_rd && i_mem_wr) || i_mem_addr[0]));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = i_mem_addr[0];
  assign o_err           = 1'b0;
`endif

  assign o_mem_wait        = wait_now;
  assign o_mem_rddatavalid = pvld_q[RD_LATENCY-1];
  assign o_mem_rddata      = pdat_q[RD_LATENCY-1];
  assign o_int_valid       = int_valid_q;
  assign o_int_data        = int_data_q;
  assign o_str_valid       = str_valid_q;
  assign o_str_addr        = str_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================================
// tb_mem_bus_responder: directed scoreboard bench for mem_bus_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_responder;

  localparam int A_WAIT = 1;
  localparam int A_LAT  = 2;
  localparam int B_WAIT = 0;
  localparam int B_LAT  = 3;
`ifdef MEM_RESP_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   started = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic [15:0] a_addr = '0, a_wd = '0;
  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic        a_wait, a_valid, a_int_valid, a_str_valid, a_err;
  logic [15:0] a_rdata, a_int_data, a_str_addr;

  logic [15:0] b_addr = '0, b_wd = '0;
  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic        b_wait, b_valid, b_int_valid, b_str_valid, b_err;
  logic [15:0] b_rdata, b_int_data, b_str_addr;

  logic [15:0] b_rd_addrs [5];
  logic [15:0] b_rd_exp   [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_responder #(
    .DEPTH_WORDS(4096), .WAIT_CYCLES(A_WAIT), .RD_LATENCY(A_LAT), .MMIO_BASE(16'h1000)
  ) dut_a (
    .clk(clk), .reset(reset), .i_mem_addr(a_addr), .i_mem_rd(a_rd), .i_mem_wr(a_wr),
    .i_mem_wrdata(a_wd), .o_mem_wait(a_wait), .o_mem_rddata(a_rdata),
    .o_mem_rddatavalid(a_valid), .o_int_valid(a_int_valid), .o_int_data(a_int_data),
    .o_str_valid(a_str_valid), .o_str_addr(a_str_addr), .o_err(a_err)
  );

  mem_bus_responder #(
    .DEPTH_WORDS(4096), .WAIT_CYCLES(B_WAIT), .RD_LATENCY(B_LAT), .MMIO_BASE(16'h1000)
  ) dut_b (
    .clk(clk), .reset(reset), .i_mem_addr(b_addr), .i_mem_rd(b_rd), .i_mem_wr(b_wr),
    .i_mem_wrdata(b_wd), .o_mem_wait(b_wait), .o_mem_rddata(b_rdata),
    .o_mem_rddatavalid(b_valid), .o_int_valid(b_int_valid), .o_int_data(b_int_data),
    .o_str_valid(b_str_valid), .o_str_addr(b_str_addr), .o_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every valid beat must match the oldest expected read.
  always @(negedge clk) begin
    if (started) begin
      if (a_valid === 1'b1) begin
        if (qa.size() == 0) begin
          check("a_spurious_valid", {31'd0, a_valid}, 32'd0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          check("a_rddata", {16'd0, a_rdata}, {16'd0, e.data});
          check("a_latency", cyc, e.cyc);
        end
      end else begin
        check("a_rddata_idle_zero", {16'd0, a_rdata}, 32'd0);
      end
      if (b_valid === 1'b1) begin
        if (qb.size() == 0) begin
          check("b_spurious_valid", {31'd0, b_valid}, 32'd0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          check("b_rddata", {16'd0, b_rdata}, {16'd0, e.data});
          check("b_latency", cyc, e.cyc);
        end
      end else begin
        check("b_rddata_idle_zero", {16'd0, b_rdata}, 32'd0);
      end
    end
  end

  // Holds a request on DUT A until accepted, checking the wait-state count.
  task automatic a_xfer(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp, input bit track);
    int waits;
    exp_t e;
    waits = 0;
    a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wdata;
    @(negedge clk);
    while (a_wait === 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("a_wait_cycles", waits, A_WAIT);
    @(posedge clk);
    #1;
    if (rd && !wr && track) begin
      e.data = exp;
      e.cyc  = cyc + A_LAT - 1;
      qa.push_back(e);
    end
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  initial begin
    b_rd_addrs = '{16'h0020, 16'h0000, 16'h0002, 16'h0004, 16'h0006};
    b_rd_exp   = '{16'h5A5A, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_a_rddata", {16'd0, a_rdata}, 32'd0);
    check("rst_a_int", {15'd0, a_int_valid, a_int_data}, 32'd0);
    check("rst_a_str", {15'd0, a_str_valid, a_str_addr}, 32'd0);
    check("rst_a_err", {31'd0, a_err}, 32'd0);
    reset = 1'b1;
    started = 1'b1;

    // DUT B: zero wait states, back-to-back traffic.
    @(posedge clk); #1;
    b_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_addr = 16'(i * 2);
      b_wd   = 16'(i + 1);
      @(negedge clk);
      check("b_wait_wr", {31'd0, b_wait}, 32'd0);
      @(posedge clk); #1;
    end
    b_addr = 16'h0020; b_wd = 16'h5A5A;
    @(negedge clk);
    check("b_wait_wr", {31'd0, b_wait}, 32'd0);
    @(posedge clk); #1;
    b_wr = 1'b0; b_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      b_addr = b_rd_addrs[i];
      @(negedge clk);
      check("b_wait_rd", {31'd0, b_wait}, 32'd0);
      @(posedge clk); #1;
      e.data = b_rd_exp[i];
      e.cyc  = cyc + B_LAT - 1;
      qb.push_back(e);
    end
    b_rd = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // DUT A: one wait state, RAM and MMIO traffic.
    a_xfer(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    a_xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
    a_xfer(1'b0, 1'b1, 16'h1000, 16'h002A, 16'h0000, 1'b0);
    check("int_valid_pulse", {31'd0, a_int_valid}, 32'd1);
    check("int_data", {16'd0, a_int_data}, 32'h002A);
    @(posedge clk); #1;
    check("int_valid_drop", {31'd0, a_int_valid}, 32'd0);
    a_xfer(1'b1, 1'b0, 16'h1004, 16'h0000, 16'h0001, 1'b1);
    a_xfer(1'b0, 1'b1, 16'h1002, 16'h0200, 16'h0000, 1'b0);
    check("str_valid_pulse", {31'd0, a_str_valid}, 32'd1);
    check("str_addr", {16'd0, a_str_addr}, 32'h0200);
    @(posedge clk); #1;
    check("str_valid_drop", {31'd0, a_str_valid}, 32'd0);
    a_xfer(1'b1, 1'b0, 16'h1004, 16'h0000, 16'h0002, 1'b1);
    a_xfer(1'b0, 1'b1, 16'h1004, 16'hFFFF, 16'h0000, 1'b0);
    a_xfer(1'b1, 1'b0, 16'h1004, 16'h0000, 16'h0002, 1'b1);
    a_xfer(1'b1, 1'b0, 16'h1000, 16'h0000, 16'h002A, 1'b1);
    a_xfer(1'b1, 1'b0, 16'h1002, 16'h0000, 16'h0200, 1'b1);
    a_xfer(1'b1, 1'b0, 16'h1006, 16'h0000, 16'h0000, 1'b1);
    a_xfer(1'b0, 1'b1, 16'h4000, 16'h1234, 16'h0000, 1'b0);
    a_xfer(1'b1, 1'b0, 16'h4000, 16'h0000, 16'h0000, 1'b1);
    check("err_clean", {31'd0, a_err}, 32'd0);
    a_xfer(1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b1);
    check("err_odd_addr", {31'd0, a_err}, {31'd0, ERR_EXP});
    a_xfer(1'b1, 1'b1, 16'h0012, 16'h7777, 16'h0000, 1'b1);
    a_xfer(1'b1, 1'b0, 16'h0012, 16'h0000, 16'h7777, 1'b1);
    check("err_sticky", {31'd0, a_err}, {31'd0, ERR_EXP});
    repeat (5) @(posedge clk);
    #1;
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    // Reset while a read is in flight: its response must never appear.
    a_xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_valid", {31'd0, a_valid}, 32'd0);
    check("mid_rst_rddata", {16'd0, a_rdata}, 32'd0);
    check("mid_rst_int", {15'd0, a_int_valid, a_int_data}, 32'd0);
    check("mid_rst_str", {15'd0, a_str_valid, a_str_addr}, 32'd0);
    check("mid_rst_err", {31'd0, a_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    a_xfer(1'b1, 1'b0, 16'h1004, 16'h0000, 16'h0000, 1'b1);
    a_xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("a_queue_final", qa.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave end of the CPU memory bus: the block that answers the CPU's read and write requests on that bus.
- Holds an internal word RAM.
- Generates wait states and pipelined read-data-valid responses.
- Decodes a small MMIO window: integer-result, string-address and result-count registers.
- Replaces the zero-wait, always-valid memory model so the CPU's wait and rddatavalid handling is exercised.

Parameters:
- DEPTH_WORDS, 4096: internal RAM size in 16-bit words; covers byte addresses 0 .. 2*DEPTH_WORDS-1.
- WAIT_CYCLES, 1: wait-state cycles inserted before each request is accepted; 0 means never wait.
- RD_LATENCY, 2: cycles from read acceptance edge to o_mem_rddatavalid; legal range 1..8.
- MMIO_BASE, 16'h1000: base byte address of the MMIO window (16 bytes, takes priority over RAM).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- i_mem_addr  input  16  byte address from CPU; word index is i_mem_addr[15:1]
- i_mem_rd  input  1  read request
- i_mem_wr  input  1  write request
- i_mem_wrdata  input  16  write data
- o_mem_wait  output  1  request stalled this cycle (combinational from request and wait counter)
- o_mem_rddata  output  16  read data, meaningful only with o_mem_rddatavalid
- o_mem_rddatavalid  output  1  read data valid, one cycle per accepted read
- o_int_valid  output  1  one-cycle pulse: integer result written
- o_int_data  output  16  last integer result
- o_str_valid  output  1  one-cycle pulse: string address written
- o_str_addr  output  16  last string address
- o_err  output  1  sticky protocol error (optional feature)

Behaviour:
- Reset (reset==0 at a clk edge):
  - o_mem_rddatavalid=0, o_mem_rddata=16'h0000.
  - o_int_valid=0, o_str_valid=0, o_int_data=0, o_str_addr=0, o_err=0.
  - Wait counter=0, result count=0, read pipeline flushed.
  - RAM contents are not cleared.
- Reset mid-operation: in-flight reads are dropped; no rddatavalid is issued for them.
- Request: i_mem_rd or i_mem_wr high. A request is accepted on a rising edge where it is present and o_mem_wait==0.
- Wait generation:
  - o_mem_wait = request && (wcnt != WAIT_CYCLES).
  - While a request is present and wait is asserted, wcnt increments.
  - On acceptance, wcnt returns to 0.
  - Requests must be held stable while o_mem_wait=1.
  - If the request drops while waited, wcnt returns to 0.
  - Back-to-back requests each incur WAIT_CYCLES wait cycles.
- Read pipeline:
  - An accepted read produces o_mem_rddatavalid=1 exactly RD_LATENCY cycles after the accept edge, carrying the data sampled at accept.
  - Reads are in order; up to RD_LATENCY reads outstanding; no back-pressure.
  - o_mem_rddata=16'h0000 whenever o_mem_rddatavalid=0.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Decode priority: MMIO window, then RAM, then unmapped.
  - Unmapped reads return 16'h0000.
  - Unmapped writes are ignored.
- MMIO map (offsets from MMIO_BASE):
  - +0: write sets o_int_data and pulses o_int_valid; read returns o_int_data.
  - +2: write sets o_str_addr and pulses o_str_valid; read returns o_str_addr.
  - +4: read-only 16-bit result count, incremented on each +0 or +2 write, wraps 16'hFFFF to 0; writes ignored.
  - +6..+E: reserved; reads return 0.
- MMIO pulse timing: o_int_valid / o_str_valid rise the cycle after the accept edge and last exactly one cycle.
- Simultaneous rd and wr: the write is performed; no read response is generated.
- Address bit [0] is ignored (word access only).

Optional Feature:
- Macro: MEM_RESP_ERRCHK_EN.
- Defined: o_err sets and stays set until reset on either of:
  - an accepted request with i_mem_rd && i_mem_wr;
  - an accepted request with i_mem_addr[0]==1.
  The request is still serviced as described in Behaviour.
- Undefined: no checking logic; o_err is tied to 0.

Test Plan:
- WAIT_CYCLES=1, RD_LATENCY=2: write 16'hBEEF to 0x0010, then read 0x0010 -> o_mem_wait high 1 cycle per request; rddatavalid with 16'hBEEF exactly 2 cycles after read accept.
- WAIT_CYCLES=0: four back-to-back reads of 0x0000, 0x0002, 0x0004, 0x0006 preloaded with 1..4 -> valid on 4 consecutive cycles with data 1,2,3,4 in order; o_mem_wait never high.
- Write 16'h002A to 0x1000 -> o_int_valid one-cycle pulse, o_int_data=16'h002A; read 0x1004 returns 1.
- Write 16'h0200 to 0x1002 -> o_str_valid pulse, o_str_addr=16'h0200; read 0x1004 returns 2.
- Issue a read, assert reset=0 before its rddatavalid -> no rddatavalid; all outputs 0 after reset.
- With MEM_RESP_ERRCHK_EN: read 0x0011 -> o_err=1, stays set until reset. Without the macro: o_err stays 0.
